hacc_array: RTL and testbench

Bit-stream accumulator array that produces the binary sums consumed by the activation array. Each cycle, for every one of `ODIM` channels, it popcounts `ADIM` stochastic product bits, for example XNOR outputs of a bipolar multiplier row. It accumulates the counts over one stream window of `2**OWID` valid cycles, then presents the offset-encoded totals with a one-cycle valid pulse. The block sits between the stochastic MAC row and the activation stage. Its outputs feed the activation array's `iData` directly, with zero at `ADIM*(2**OWID)/2`.

---
 rtl/hacc_pkg.sv | 15 +
 rtl/hpopcnt.sv | 31 +++
 rtl/hacc_array.sv | 115 +++++++++++
 tb/tb_hacc_array.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hacc_pkg.sv
// Shared helpers for the bit-stream accumulator array: accumulator width rule and the
// offset-encoded zero point consumed by the activation array.
package hacc_pkg;

   // Minimum accumulator width that holds ADIM * 2**OWID without overflow.
   function automatic int unsigned acc_width(input int unsigned adim, input int unsigned owid);
      return $clog2(adim * (2 ** owid) + 1);
   endfunction

   // Window total that encodes bipolar zero.
   function automatic int unsigned pzer(input int unsigned adim, input int unsigned owid);
      return adim * (2 ** owid) / 2;
   endfunction

endpackage

// File: rtl/hpopcnt.sv
// Combinational popcount built as a balanced adder tree over a power-of-two padded input.
module hpopcnt #(
   parameter int unsigned ADIM = 32
) (
   input  logic [ADIM-1:0]          bits_i,
   output logic [$clog2(ADIM+1)-1:0] cnt_o
);

   localparam int unsigned W   = $clog2(ADIM + 1);
   localparam int unsigned LOG = $clog2(ADIM);
   localparam int unsigned N   = 1 << LOG;

   // Level 0 holds the padded leaves; level LOG holds the single root.
   for (genvar l = 0; l <= LOG; l++) begin : g_lvl
      logic [W-1:0] s [N >> l];
      for (genvar i = 0; i < (N >> l); i++) begin : g_node
         if (l == 0) begin : g_leaf
            if (i < ADIM) begin : g_bit
               assign s[i] = W'(bits_i[i]);
            end else begin : g_pad
               assign s[i] = '0;
            end
         end else begin : g_add
            assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
         end
      end
   end

   assign cnt_o = g_lvl[LOG].s[0];

endmodule

// File: rtl/hacc_array.sv
// Bit-stream accumulator array: per-channel popcount stage feeding a window accumulator
// that publishes totals with a one-cycle valid pulse every 2**OWID valid beats.
module hacc_array
   import hacc_pkg::*;
#(
   parameter int unsigned ODIM = 4,
   parameter int unsigned ADIM = 32,
   parameter int unsigned OWID = 8,
   parameter int unsigned IWID = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iValid,
   input  logic [ADIM-1:0] iBit [ODIM],
   input  logic            iClear,
   output logic [IWID-1:0] oData [ODIM],
   output logic            oValid,
   output logic            oBusy
);

   localparam int unsigned PW = $clog2(ADIM + 1);

   if (IWID < acc_width(ADIM, OWID)) begin : g_width_chk
      $error("hacc_array: IWID too narrow for ADIM * 2**OWID");
   end

   logic [PW-1:0]   pc_raw [ODIM];

   logic [OWID-1:0] cnt_q, cnt_d;
   logic            pv_q, pv_d;
   logic            plast_q, plast_d;
   logic [PW-1:0]   pc_q [ODIM];
   logic [PW-1:0]   pc_d [ODIM];
   logic [IWID-1:0] acc_q [ODIM];
   logic [IWID-1:0] acc_d [ODIM];
   logic [IWID-1:0] odata_q [ODIM];
   logic [IWID-1:0] odata_d [ODIM];
   logic            ovalid_q, ovalid_d;

   for (genvar c = 0; c < ODIM; c++) begin : g_pc
      hpopcnt #(
         .ADIM (ADIM)
      ) u_hpopcnt (
         .bits_i (iBit[c]),
         .cnt_o  (pc_raw[c])
      );
   end

   always_comb begin
      cnt_d    = cnt_q;
      pv_d     = 1'b0;
      plast_d  = plast_q;
      pc_d     = pc_q;
      acc_d    = acc_q;
      odata_d  = odata_q;
      ovalid_d = 1'b0;

      if (iValid) begin
         pc_d    = pc_raw;
         pv_d    = 1'b1;
         plast_d = (cnt_q == '1);
         cnt_d   = cnt_q + 1'b1;
      end

      if (pv_q) begin
         for (int c = 0; c < ODIM; c++) begin
            if (plast_q) begin
               odata_d[c] = acc_q[c] + IWID'(pc_q[c]);
               acc_d[c]   = '0;
            end else begin
               acc_d[c]   = acc_q[c] + IWID'(pc_q[c]);
            end
         end
         ovalid_d = plast_q;
      end

      // Abort drops both the incoming beat and any window closing in stage 2.
      if (iClear) begin
         cnt_d    = '0;
         pv_d     = 1'b0;
         ovalid_d = 1'b0;
         odata_d  = odata_q;
         for (int c = 0; c < ODIM; c++) begin
            acc_d[c] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         pv_q     <= 1'b0;
         plast_q  <= 1'b0;
         ovalid_q <= 1'b0;
         for (int c = 0; c < ODIM; c++) begin
            pc_q[c]    <= '0;
            acc_q[c]   <= '0;
            odata_q[c] <= '0;
         end
      end else begin
         cnt_q    <= cnt_d;
         pv_q     <= pv_d;
         plast_q  <= plast_d;
         ovalid_q <= ovalid_d;
         pc_q     <= pc_d;
         acc_q    <= acc_d;
         odata_q  <= odata_d;
      end
   end

   assign oData  = odata_q;
   assign oValid = ovalid_q;
   assign oBusy  = (cnt_q != '0) || pv_q;

endmodule

// File: tb/tb_hacc_array.sv
// Directed bench for hacc_array: window-level reference model checked every cycle, plus
// hand-computed expectations at window boundaries.
module tb_hacc_array;

   localparam int ODIM = 4;
   localparam int ADIM = 32;
   localparam int OWID = 8;
   localparam int IWID = 16;
   localparam int WIN  = 1 << OWID;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            iValid = 1'b0;
   logic            iClear = 1'b0;
   logic [ADIM-1:0] iBit [ODIM];
   logic [IWID-1:0] oData [ODIM];
   logic            oValid;
   logic            oBusy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hacc_array #(
      .ODIM (ODIM),
      .ADIM (ADIM),
      .OWID (OWID),
      .IWID (IWID)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .iValid (iValid),
      .iBit   (iBit),
      .iClear (iClear),
      .oData  (oData),
      .oValid (oValid),
      .oBusy  (oBusy)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Window-level reference: sums valid beats, publishes a window one edge after its last beat.
   int m_sum [ODIM];
   int m_pdata [ODIM];
   int m_odata [ODIM];
   int m_cnt = 0;
   int m_pend = 0;
   int m_ovalid = 0;
   int m_busy = 0;

   initial begin
      for (int c = 0; c < ODIM; c++) begin
         m_sum[c] = 0;
         m_pdata[c] = 0;
         m_odata[c] = 0;
      end
      forever begin
         int beat;
         @(posedge clk);
         beat = 0;
         if (rst) begin
            for (int c = 0; c < ODIM; c++) begin
               m_sum[c] = 0;
               m_odata[c] = 0;
            end
            m_cnt = 0;
            m_pend = 0;
            m_ovalid = 0;
         end else if (iClear) begin
            for (int c = 0; c < ODIM; c++) m_sum[c] = 0;
            m_cnt = 0;
            m_pend = 0;
            m_ovalid = 0;
         end else begin
            m_ovalid = m_pend;
            if (m_pend != 0) m_odata = m_pdata;
            m_pend = 0;
            if (iValid) begin
               beat = 1;
               for (int c = 0; c < ODIM; c++) m_sum[c] += $countones(iBit[c]);
               m_cnt++;
               if (m_cnt == WIN) begin
                  m_pend = 1;
                  m_pdata = m_sum;
                  for (int c = 0; c < ODIM; c++) m_sum[c] = 0;
                  m_cnt = 0;
               end
            end
         end
         m_busy = (m_cnt != 0 || beat != 0) ? 1 : 0;
         #1;
         check("model oValid", int'(oValid), m_ovalid);
         check("model oBusy", int'(oBusy), m_busy);
         for (int c = 0; c < ODIM; c++)
            check($sformatf("model oData[%0d]", c), int'(oData[c]), m_odata[c]);
      end
   end

   // mode: 0 all ones, 1 all zeros, 2 channel c gets c+1 ones, 3 random. gap: % idle cycles.
   task automatic run_beats(input int n, input int mode, input int gap);
      int done = 0;
      while (done < n) begin
         @(negedge clk);
         rst = 1'b0;
         iClear = 1'b0;
         if (gap > 0 && $urandom_range(99) < gap) begin
            iValid = 1'b0;
         end else begin
            iValid = 1'b1;
            done++;
         end
         for (int c = 0; c < ODIM; c++) begin
            case (mode)
               0: iBit[c] = '1;
               1: iBit[c] = '0;
               2: iBit[c] = ADIM'((64'd1 << (c + 1)) - 64'd1);
               default: iBit[c] = $urandom;
            endcase
         end
      end
   endtask

   // Idles one edge after the last beat, then samples just past the publishing edge.
   task automatic end_window();
      @(negedge clk);
      iValid = 1'b0;
      iClear = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string name, input int v, input int d0, input int d1,
                            input int d2, input int d3);
      int exp [ODIM];
      exp[0] = d0; exp[1] = d1; exp[2] = d2; exp[3] = d3;
      check({name, " oValid"}, int'(oValid), v);
      for (int c = 0; c < ODIM; c++)
         check($sformatf("%s oData[%0d]", name, c), int'(oData[c]), exp[c]);
   endtask

   initial begin
      for (int c = 0; c < ODIM; c++) iBit[c] = '0;
      repeat (2) @(negedge clk);
      check_all("reset", 0, 0, 0, 0, 0);
      check("reset oBusy", int'(oBusy), 0);

      // Continuous all-ones window.
      run_beats(WIN, 0, 0);
      end_window();
      check_all("ones", 1, 8192, 8192, 8192, 8192);
      check("ones oBusy", int'(oBusy), 0);

      // Graded ones per channel, then a random window left to the model.
      run_beats(WIN, 2, 0);
      end_window();
      check_all("graded", 1, 256, 512, 768, 1024);
      run_beats(WIN, 3, 0);
      end_window();

      // Gappy all-ones window.
      run_beats(WIN, 0, 50);
      end_window();
      check_all("gaps", 1, 8192, 8192, 8192, 8192);

      // Back-to-back windows with no bubble.
      run_beats(WIN, 0, 0);
      run_beats(1, 1, 0);
      @(posedge clk);
      #1;
      check_all("b2b first", 1, 8192, 8192, 8192, 8192);
      run_beats(WIN - 1, 1, 0);
      end_window();
      check_all("b2b second", 1, 0, 0, 0, 0);

      // Clear mid-window and on the last beat.
      run_beats(WIN, 2, 0);
      end_window();
      run_beats(99, 0, 0);
      @(negedge clk);
      iValid = 1'b1;
      iClear = 1'b1;
      @(negedge clk);
      iValid = 1'b0;
      iClear = 1'b0;
      check("clear100 oBusy", int'(oBusy), 0);
      run_beats(WIN - 1, 0, 0);
      @(negedge clk);
      iValid = 1'b1;
      iClear = 1'b1;
      @(negedge clk);
      iValid = 1'b0;
      iClear = 1'b0;
      @(posedge clk);
      #1;
      check_all("clear256", 0, 256, 512, 768, 1024);
      check("clear256 oBusy", int'(oBusy), 0);

      // Clear landing while the last beat sits in stage 2.
      run_beats(WIN, 0, 0);
      @(negedge clk);
      iValid = 1'b0;
      iClear = 1'b1;
      @(posedge clk);
      #1;
      check_all("clear stage2", 0, 256, 512, 768, 1024);
      run_beats(WIN, 0, 0);
      end_window();
      check_all("after clear", 1, 8192, 8192, 8192, 8192);

      // Reset mid-window.
      run_beats(50, 2, 0);
      @(negedge clk);
      rst = 1'b1;
      iValid = 1'b1;
      @(posedge clk);
      #1;
      check_all("rst mid", 0, 0, 0, 0, 0);
      check("rst mid oBusy", int'(oBusy), 0);
      run_beats(WIN, 2, 0);
      end_window();
      check_all("after rst", 1, 256, 512, 768, 1024);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
